// File: rtl/mul_cell_seq.sv
// Sequencer and round-robin two-port arbiter for the 32x32 multiply cell.
// It issues one operand pair, waits out the cell latency, then folds p1..p3 into a 32-bit product.
module mul_cell_seq #(
    parameter int unsigned CELL_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [31:0] req0_src1_i,
    input  logic [31:0] req0_src2_i,
    input  logic [31:0] req1_src1_i,
    input  logic [31:0] req1_src2_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [31:0] rsp_result_o,
    output logic        busy_o,
    output logic [31:0] cell_src1_o,
    output logic [31:0] cell_src2_o,
    output logic        cell_en_o,
    input  logic [31:0] cell_p1_i,
    input  logic [31:0] cell_p2_i,
    input  logic [31:0] cell_p3_i
);

    localparam int unsigned CntW = 3;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCombine,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     op1_q, op1_d;
    logic [31:0]     op2_q, op2_d;
    logic            id_q, id_d;
    logic [31:0]     result_q, result_d;
    logic            grant;
    logic [31:0]     pp_sum;

    // A tie goes to whichever requester was not served last.
    always_comb begin
        grant = 1'b0;
        if (req_valid_i == 2'b10) begin
            grant = 1'b1;
        end else if (req_valid_i == 2'b11) begin
            grant = ~last_q;
        end
    end

    // Only the low 16 bits of p2+p3 survive the shift into a 32-bit product.
    assign pp_sum = cell_p2_i + cell_p3_i;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        id_d        = id_q;
        result_d    = result_q;
        req_ready_o = 2'b00;
        rsp_valid_o = 1'b0;
        cell_en_o   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!reset_i && (|req_valid_i)) begin
                    req_ready_o = grant ? 2'b10 : 2'b01;
                    op1_d       = grant ? req1_src1_i : req0_src1_i;
                    op2_d       = grant ? req1_src2_i : req0_src2_i;
                    id_d        = grant;
                    last_d      = grant;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                cell_en_o = 1'b1;
                cnt_d     = CntW'(CELL_LATENCY - 1);
                state_d   = (CELL_LATENCY <= 1) ? StCombine : StWait;
            end
            StWait: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q <= CntW'(1)) begin
                    state_d = StCombine;
                end
            end
            StCombine: begin
                result_d = cell_p1_i + (pp_sum << 16);
                state_d  = StResp;
            end
            StResp: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            id_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            id_q     <= id_d;
            result_q <= result_d;
        end
    end

    assign rsp_id_o     = id_q;
    assign rsp_result_o = result_q;
    assign busy_o       = (state_q != StIdle);
    assign cell_src1_o  = op1_q;
    assign cell_src2_o  = op2_q;

endmodule
